line_bank_scheduler: RTL and testbench

- Sequences the two-bank (ping-pong) line buffer between the pixel generator (writer) and the panel driver (reader).
- While the driver scans row r out of one bank for PLANE_COUNT bit-plane passes, the generator fills row r+1 into the other bank. The banks swap at each row boundary.
- Maintains the generator row, driver row, bit-plane and frame counters.
- Sits in the top-level controller, between the counters/handshakes and the generator and driver start/idle ports.

---
 rtl/line_bank_scheduler.sv | 158 +++++++++++++++
 tb/tb_line_bank_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_bank_scheduler.sv
`default_nettype none
// line_bank_scheduler: ping-pong line-buffer sequencer between the pixel generator and the panel driver.
// Rev 1.0
module line_bank_scheduler #(
  parameter  int ROW_COUNT   = 32,
  parameter  int PLANE_COUNT = 8,
  parameter  int FRAME_BITS  = 10,
  localparam int RW = ($clog2(ROW_COUNT) > 1) ? $clog2(ROW_COUNT) : 1,
  localparam int PW = ($clog2(PLANE_COUNT) > 1) ? $clog2(PLANE_COUNT) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  gen_start,
  output logic [RW-1:0]         gen_row,
  output logic                  gen_bank,
  input  logic                  gen_idle,
  output logic                  drv_start,
  output logic [RW-1:0]         drv_row,
  output logic                  drv_bank,
  output logic [PW-1:0]         drv_plane,
  input  logic                  drv_idle,
  output logic [FRAME_BITS-1:0] frame_count,
  output logic                  frame_strobe,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PRIME_START = 3'd1;
  localparam logic [2:0] S_PRIME_WAIT  = 3'd2;
  localparam logic [2:0] S_SLOT_START  = 3'd3;
  localparam logic [2:0] S_SLOT_WAIT   = 3'd4;

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROW_COUNT - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANE_COUNT - 1);

  logic [2:0]            state, state_nx;
  logic                  wait_first, wait_first_nx;
  logic                  gen_start_nx, drv_start_nx;
  logic [RW-1:0]         gen_row_nx, drv_row_nx;
  logic                  gen_bank_nx, drv_bank_nx;
  logic [PW-1:0]         drv_plane_nx;
  logic [FRAME_BITS-1:0] frame_count_nx;
  logic                  frame_strobe_nx;
  logic                  busy_nx;
  logic                  last_plane;
  logic                  slot_done;

  // Requesters may need a cycle to drop idle, so the first WAIT cycle never exits.
  // The generator job of a row only has to be finished at the row boundary.
  assign last_plane = (drv_plane == PLANE_LAST);
  assign slot_done  = !wait_first && drv_idle && (!last_plane || gen_idle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wait_first   <= 1'b0;
      gen_start    <= 1'b0;
      drv_start    <= 1'b0;
      gen_row      <= '0;
      drv_row      <= '0;
      gen_bank     <= 1'b0;
      drv_bank     <= 1'b1;
      drv_plane    <= '0;
      frame_count  <= '0;
      frame_strobe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      wait_first   <= wait_first_nx;
      gen_start    <= gen_start_nx;
      drv_start    <= drv_start_nx;
      gen_row      <= gen_row_nx;
      drv_row      <= drv_row_nx;
      gen_bank     <= gen_bank_nx;
      drv_bank     <= drv_bank_nx;
      drv_plane    <= drv_plane_nx;
      frame_count  <= frame_count_nx;
      frame_strobe <= frame_strobe_nx;
      busy         <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (enable) state_nx = S_PRIME_START;
      S_PRIME_START: state_nx = S_PRIME_WAIT;
      S_PRIME_WAIT:  if (!wait_first && gen_idle) state_nx = S_SLOT_START;
      S_SLOT_START:  state_nx = S_SLOT_WAIT;
      S_SLOT_WAIT: begin
        if (slot_done) state_nx = (!last_plane || enable) ? S_SLOT_START : S_IDLE;
      end
      default:       state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    gen_start_nx    = 1'b0;
    drv_start_nx    = 1'b0;
    frame_strobe_nx = 1'b0;
    gen_row_nx      = gen_row;
    drv_row_nx      = drv_row;
    gen_bank_nx     = gen_bank;
    drv_bank_nx     = drv_bank;
    drv_plane_nx    = drv_plane;
    frame_count_nx  = frame_count;
    busy_nx         = (state_nx != S_IDLE);
    wait_first_nx   = ((state == S_PRIME_START) && (state_nx == S_PRIME_WAIT)) ||
                      ((state == S_SLOT_START)  && (state_nx == S_SLOT_WAIT));
    case (state)
      S_IDLE: begin
        if (enable) begin
          gen_start_nx = 1'b1;
          gen_row_nx   = '0;
          gen_bank_nx  = 1'b0;
          drv_bank_nx  = 1'b1;
        end
      end
      S_PRIME_WAIT: begin
        if (state_nx == S_SLOT_START) begin
          drv_row_nx   = '0;
          drv_bank_nx  = 1'b0;
          gen_row_nx   = RW'(1);
          gen_bank_nx  = 1'b1;
          drv_plane_nx = '0;
          drv_start_nx = 1'b1;
          gen_start_nx = 1'b1;
        end
      end
      S_SLOT_WAIT: begin
        if (slot_done) begin
          if (!last_plane) begin
            drv_plane_nx = drv_plane + PW'(1);
            drv_start_nx = 1'b1;
          end else begin
            gen_bank_nx  = ~gen_bank;
            drv_bank_nx  = ~drv_bank;
            drv_row_nx   = gen_row;
            gen_row_nx   = (gen_row == ROW_LAST) ? '0 : gen_row + RW'(1);
            drv_plane_nx = '0;
            if (drv_row == ROW_LAST) begin
              frame_count_nx  = frame_count + FRAME_BITS'(1);
              frame_strobe_nx = 1'b1;
            end
            if (enable) begin
              drv_start_nx = 1'b1;
              gen_start_nx = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_line_bank_scheduler.sv
`default_nettype none
// tb_line_bank_scheduler: directed + randomized bench with a transaction-level reference model.
// Rev 1.0
module tb_line_bank_scheduler;

  localparam int RC = 4;
  localparam int PC = 2;
  localparam int FB = 10;
  localparam int RW = 2;
  localparam int PW = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          gen_idle = 1'b1;
  logic          drv_idle = 1'b1;
  logic          gen_start, drv_start, gen_bank, drv_bank, frame_strobe, busy;
  logic [RW-1:0] gen_row, drv_row;
  logic [PW-1:0] drv_plane;
  logic [FB-1:0] frame_count;

  int vectors = 0, miscompares = 0;
  int cyc = 0, ws = 0, m_phase = 0;
  int e_gen_row, e_gen_bank, e_drv_row, e_drv_bank, e_plane, e_frames, e_busy, e_gs, e_ds, e_fs;
  int dcnt = 0, gcnt = 0, drv_lat = 3, gen_lat = 3;
  int strobes = 0, starts = 0;
  bit rec = 1'b0;
  int q_row[$], q_plane[$], q_bank[$];

  line_bank_scheduler #(.ROW_COUNT(RC), .PLANE_COUNT(PC), .FRAME_BITS(FB)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .gen_start(gen_start), .gen_row(gen_row), .gen_bank(gen_bank), .gen_idle(gen_idle),
    .drv_start(drv_start), .drv_row(drv_row), .drv_bank(drv_bank), .drv_plane(drv_plane),
    .drv_idle(drv_idle), .frame_count(frame_count), .frame_strobe(frame_strobe), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_gen_row = 0; e_gen_bank = 0; e_drv_row = 0; e_drv_bank = 1; e_plane = 0;
    e_frames = 0; e_busy = 0; e_gs = 0; e_ds = 0; e_fs = 0; m_phase = 0;
    dcnt = 0; gcnt = 0; gen_idle = 1'b1; drv_idle = 1'b1;
  endtask

  task automatic check_outputs();
    check("gen_start", gen_start, e_gs);
    check("drv_start", drv_start, e_ds);
    check("frame_strobe", frame_strobe, e_fs);
    check("busy", busy, e_busy);
    check("gen_row", gen_row, e_gen_row);
    check("gen_bank", gen_bank, e_gen_bank);
    check("drv_row", drv_row, e_drv_row);
    check("drv_bank", drv_bank, e_drv_bank);
    check("drv_plane", drv_plane, e_plane);
    check("frame_count", frame_count, e_frames);
    if (busy) check("bank_conflict", gen_bank != drv_bank, 1);
  endtask

  // One clock: decide which scheduling event the coming edge produces, then check and respond.
  task automatic tick();
    int ev, done_row;
    bit en_s;
    ev = 0;
    en_s = enable;
    case (m_phase)
      0: if (enable) ev = 1;
      1: if (cyc >= ws + 2 && gen_idle) ev = 2;
      2: if (cyc >= ws + 2 && drv_idle && (e_plane != PC - 1 || gen_idle)) ev = (e_plane != PC - 1) ? 3 : 4;
      default: ;
    endcase
    @(posedge clock);
    #1;
    cyc++;
    e_gs = 0; e_ds = 0; e_fs = 0;
    case (ev)
      1: begin
        e_gs = 1; e_gen_row = 0; e_gen_bank = 0; e_drv_bank = 1; e_busy = 1; m_phase = 1; ws = cyc;
      end
      2: begin
        e_drv_row = 0; e_drv_bank = 0; e_gen_row = 1 % RC; e_gen_bank = 1; e_plane = 0;
        e_ds = 1; e_gs = 1; m_phase = 2; ws = cyc;
      end
      3: begin
        e_plane++; e_ds = 1; ws = cyc;
      end
      4: begin
        done_row = e_drv_row;
        e_drv_row = e_gen_row;
        e_gen_row = (e_gen_row + 1) % RC;
        e_gen_bank = 1 - e_gen_bank;
        e_drv_bank = 1 - e_drv_bank;
        e_plane = 0;
        if (done_row == RC - 1) begin
          e_frames = (e_frames + 1) % (1 << FB);
          e_fs = 1;
        end
        if (en_s) begin
          e_ds = 1; e_gs = 1; ws = cyc;
        end else begin
          m_phase = 0; e_busy = 0;
        end
      end
      default: ;
    endcase
    check_outputs();
    if (frame_strobe) strobes++;
    if (drv_start) begin
      starts++;
      if (rec) begin
        q_row.push_back(int'(drv_row)); q_plane.push_back(int'(drv_plane)); q_bank.push_back(int'(drv_bank));
      end
      drv_idle = 1'b0;
      dcnt = (drv_lat != 0) ? drv_lat : int'($urandom_range(1, 6));
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) drv_idle = 1'b1;
    end
    if (gen_start) begin
      gen_idle = 1'b0;
      gcnt = (gen_lat != 0) ? gen_lat : int'($urandom_range(1, 6));
    end else if (gcnt > 0) begin
      gcnt--;
      if (gcnt == 0) gen_idle = 1'b1;
    end
  endtask

  task automatic wait_drv_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (drv_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int k, s, fsave;
    bit ok;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();

    // Prime and first frames
    enable = 1'b1;
    rec = 1'b1;
    tick();
    check("prime_gen_start", gen_start, 1);
    check("prime_gen_row", gen_row, 0);
    check("prime_gen_bank", gen_bank, 0);
    for (k = 0; k < 1000 && e_frames < 2; k++) tick();
    check("two_frames_in_budget", k < 1000, 1);
    rec = 1'b0;
    check("strobe_count", strobes, 2);
    check("frame_count_2", frame_count, 2);
    check("pass_count", q_row.size() >= 2 * RC * PC, 1);
    for (int i = 0; i < 2 * RC * PC && i < q_row.size(); i++) begin
      check("seq_row", q_row[i], (i / PC) % RC);
      check("seq_plane", q_plane[i], i % PC);
      check("seq_bank", q_bank[i], (i / PC) % 2);
    end

    // Slow generator: plane 1 proceeds, row boundary waits on the generator
    gen_lat = 13;
    ok = 1'b0;
    for (int i = 0; i < 20 && !(ok && drv_plane == 0); i++) wait_drv_start(100, ok);
    check("slow_found_plane0", ok && drv_plane == 0, 1);
    s = cyc;
    wait_drv_start(100, ok);
    check("slow_plane1_delay", cyc - s, 4);
    wait_drv_start(100, ok);
    check("slow_boundary_delay", cyc - s, 14);
    gen_lat = 3;

    // Stop during plane 0 of row 2
    ok = 1'b0;
    for (int i = 0; i < 40 && !(ok && drv_row == 2 && drv_plane == 0); i++) wait_drv_start(100, ok);
    check("stop_found_row2", ok && drv_row == 2 && drv_plane == 0, 1);
    enable = 1'b0;
    fsave = e_frames;
    starts = 0;
    for (k = 0; k < 300 && busy; k++) tick();
    check("stop_reaches_idle", busy, 0);
    check("stop_remaining_passes", starts, 1);
    repeat (5) tick();
    enable = 1'b1;
    tick();
    check("restart_gen_start", gen_start, 1);
    check("restart_gen_row", gen_row, 0);
    check("restart_gen_bank", gen_bank, 0);
    check("restart_frame_count", frame_count, fsave);

    // Randomized latencies and enable toggling
    drv_lat = 0;
    gen_lat = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 30 == 0) enable = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Asynchronous reset while in SLOT_WAIT
    enable = 1'b1;
    for (k = 0; k < 400 && !(m_phase == 2 && cyc > ws); k++) tick();
    check("found_slot_wait", m_phase == 2 && cyc > ws, 1);
    #3 reset = 1'b0;
    #1;
    enable = 1'b0;
    model_reset();
    check("areset_busy", busy, 0);
    check("areset_gen_start", gen_start, 0);
    check("areset_drv_start", drv_start, 0);
    check("areset_drv_row", drv_row, 0);
    check("areset_gen_row", gen_row, 0);
    check("areset_plane", drv_plane, 0);
    check("areset_frame_count", frame_count, 0);
    check("areset_gen_bank", gen_bank, 0);
    check("areset_drv_bank", drv_bank, 1);
    repeat (10) tick();
    reset = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
